fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Decoupling buffer between the instruction fetch/memory stage and the decode stage.
- Captures {pc, instr} pairs produced by fetch into a small circular FIFO and presents them to decode with a valid/ready handshake.
- Absorbs decode back-pressure; discards wrong-path instructions on a taken jump (flush).

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- ADDR_W, 32, PC width (matches instr_addr_bus).
- INSTR_W, 32, instruction width (matches instr_bus).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  taken jump/branch; drop all queued and incoming entries
- in_valid  input  1  fetch presents a valid pair (driven from fetch ce)
- in_pc  input  ADDR_W  PC of incoming instruction
- in_instr  input  INSTR_W  incoming instruction word
- in_ready  output  1  queue can accept a push this cycle
- out_valid  output  1  head entry valid for decode
- out_pc  output  ADDR_W  head PC
- out_instr  output  INSTR_W  head instruction
- out_ready  input  1  decode consumes head this cycle
- count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: DEPTH-entry arrays pc_mem/instr_mem, rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, and a count register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from out_ready.
- out_valid = (count != 0). out_pc/out_instr = entry at rd_ptr when out_valid, else forced to all zeros.
- Latency: an entry pushed at edge N is visible at the outputs after edge N. No same-cycle bypass when empty.
- Push and pop in the same cycle: both pointers advance, count unchanged.
- Full: in_ready=0, so an asserted in_valid is ignored and fetch must hold. A pop while full frees a slot the next cycle.
- Empty: out_valid=0 and outputs are 0. out_ready is ignored.
- Flush (rst=0): at the next edge rd_ptr=wr_ptr=0 and count=0. Any push in the flush cycle is discarded. Any pop in the flush cycle is still treated as consumed by decode, but the queue is cleared regardless.
- Reset: at the next edge rd_ptr=wr_ptr=count=0. Then in_ready=1, out_valid=0, out_pc=0, out_instr=0. Storage arrays need no reset.
- Priority: rst > flush > push/pop. Reset mid-transfer discards all contents.
- count never exceeds DEPTH and never underflows. Implementation must hold this by construction; assertions in sim.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined: adds two 32-bit outputs.
  - stall_cnt: increments each cycle with in_valid=1 and in_ready=0.
  - flush_cnt: increments each cycle flush=1 and rst=0.
  - Both clear on rst and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 two cycles with in_valid=1 -> count=0, out_valid=0, out_pc=0, out_instr=0, in_ready=1.
- Fill/drain: out_ready=0, push pc 0x3000_0000/instr 0x0000_0013, then 0x3000_0004/0x0050_0093 -> count=2, in_ready=0. A third push of 0x3000_0008 is ignored. Raise out_ready -> decode receives 0x3000_0000 then 0x3000_0004 in order; then out_valid=0.
- Streaming: in_valid=1, out_ready=1 continuously, PCs incrementing by 4 from 0x3000_0000 -> after first-cycle latency one instruction per cycle, count stays 1, no PC skipped or duplicated across pointer wrap (>= 3*DEPTH pushes).
- Flush: queue holds 0x3000_0008 and 0x3000_000C; assert flush with in_valid=1 in_pc=0x3000_0010 -> next cycle count=0, out_valid=0. Then push 0x3000_0100 -> it is the next out_pc.
- Reset mid-operation: queue full, assert rst and flush together -> next cycle empty, in_ready=1. With FETCH_QUEUE_PERF_EN: flush_cnt=0.
- Perf (macro on): hold queue full with in_valid=1 for 5 cycles, then one flush -> stall_cnt=5, flush_cnt=1.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between instruction fetch and decode.
// Holds {pc, instr} pairs in a DEPTH-entry circular buffer and hands them to
// decode over a valid/ready handshake. A flush (taken jump) drops every queued
// and incoming entry.
// Optional macro FETCH_QUEUE_PERF_EN adds stall_cnt/flush_cnt perf counters.
module fetch_queue #(
  parameter int DEPTH   = 2,   // power of two, >= 2
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  // Storage; no reset needed because out_valid gates what decode sees.
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Handshake flags come purely from registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // Head entry is forced to zero while empty so decode never sees stale data.
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;

  // Next-state for pointers and occupancy; flush overrides push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; a push in a flush or reset cycle is simply not stored.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Perf counters: fetch stalls on a full queue, and flushes seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush)                 flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

`ifndef SYNTHESIS
  // Simulation-only sanity checks on occupancy and pointer consistency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert (!(pop && empty));
      assert (!(push && full));
      assert ((wr_ptr_q - rd_ptr_q) == PTR_W'(count_q));
    end
  end
`endif

endmodule
